instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the vector CPU decode/datapath. Owns the program counter, issues word fetches to a synchronous instruction memory (1-cycle read latency), buffers returned 30-bit instructions with their PCs in a small prefetch FIFO, and presents them to decode through a valid/ready handshake. Supports redirect (branch/jump) with flush of buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues fetches to a 1-cycle synchronous
// instruction memory and buffers returned words in a prefetch FIFO for decode.
module instr_fetch_unit #(
  parameter int IW = 30,
  parameter int AW = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 1,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [IW-1:0]            imem_data,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic [IW-1:0]            instr,
  output logic [AW-1:0]            instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] credit;
  logic          pop;
  logic          push;

  // Decode handshake: an entry transfers on any cycle where instr_valid and
  // instr_ready are both high; instr_valid never depends on instr_ready.
  assign pop    = instr_valid && instr_ready;
  assign push   = inflight && !redirect;
  // Slots that would be occupied after this cycle if no new fetch were issued.
  assign credit = count + CW'(inflight) - CW'(pop);

  assign imem_req  = !rst && !redirect && (credit < CW'(DEPTH));
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      // Head handshake this cycle is consumed; everything else is dropped.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + AW'(PC_STEP);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? instr_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: synchronous memory model, expected-PC queue
// scoreboard, directed latency/backpressure/redirect cases and a random phase.
module tb_instr_fetch_unit;

  localparam int IW = 30;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  localparam logic [AW-1:0] WRAP_PC = 32'hFFFF_FFFE;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_ready = 1'b0;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data = '0;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [CW-1:0] fifo_count;

  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [IW-1:0] w_data = '0;
  logic [IW-1:0] w_instr;
  logic [AW-1:0] w_instr_pc;
  logic          w_valid;
  logic [CW-1:0] w_count;

  instr_fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC('0)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  instr_fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_data(w_data),
    .redirect(1'b0), .redirect_pc('0), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_valid(w_valid), .instr_ready(1'b1), .fifo_count(w_count)
  );

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return a[IW-1:0] ^ 30'h15A5_A5A5;
  endfunction

  // synchronous instruction memories, 1-cycle read latency
  always @(posedge clk) begin
    if (imem_req) imem_data <= mem_word(imem_addr);
    if (w_req)    w_data    <= mem_word(w_addr);
  end

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  int n_hs = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] next_push;
  logic          prev_flush = 1'b0;

  logic          s_req, s_valid, w_s_valid;
  logic [AW-1:0] s_addr, s_pc, w_s_pc;
  logic [IW-1:0] s_instr;
  logic [CW-1:0] s_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_push);
      next_push = next_push + 32'd1;
    end
  endtask

  task automatic restart(input logic [AW-1:0] pc);
    exp_q.delete();
    next_push = pc;
    top_up();
  endtask

  // One clock: inputs already driven; sample 1ns after the falling edge,
  // score the handshake, then advance to the next falling edge.
  task automatic cycle();
    logic [AW-1:0] e;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_pc = instr_pc; s_instr = instr; s_count = fifo_count;
    w_s_valid = w_valid; w_s_pc = w_instr_pc;
    if (prev_flush) begin
      check_eq("flush_count", 64'(s_count), 64'd0);
      check_eq("flush_valid", 64'(s_valid), 64'd0);
    end
    if (rst) check_eq("rst_req", 64'(s_req), 64'd0);
    else if (redirect) check_eq("redir_req", 64'(s_req), 64'd0);
    if (!s_valid) check_eq("empty_zero", 64'({s_instr, s_pc}), 64'd0);
    if (!rst && s_valid && instr_ready) begin
      top_up();
      e = exp_q.pop_front();
      check_eq("sb_pc", 64'(s_pc), 64'(e));
      check_eq("sb_instr", 64'(s_instr), 64'(mem_word(e)));
      n_hs++;
    end
    if (rst) restart('0);
    else if (redirect) restart(redirect_pc);
    prev_flush = rst || redirect;
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] wexp;
    int hs_start;
    int r;
    @(negedge clk);

    // reset state
    rst = 1'b1; instr_ready = 1'b0;
    cycle(); cycle();
    check_eq("rst_addr", 64'(s_addr), 64'd0);
    check_eq("rst_count", 64'(s_count), 64'd0);
    check_eq("rst_valid", 64'(s_valid), 64'd0);
    check_eq("rst_waddr", 64'(w_addr), 64'(WRAP_PC));

    // streaming with ready=1, 2-cycle latency, wrap-around instance
    rst = 1'b0; instr_ready = 1'b1;
    cycle();
    check_eq("c0_req", 64'(s_req), 64'd1);
    check_eq("c0_addr", 64'(s_addr), 64'd0);
    check_eq("c0_valid", 64'(s_valid), 64'd0);
    cycle();
    check_eq("c1_valid", 64'(s_valid), 64'd0);
    wexp = WRAP_PC;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 0) begin
        check_eq("c2_valid", 64'(s_valid), 64'd1);
        check_eq("c2_pc", 64'(s_pc), 64'd0);
      end
      check_eq("wrap_valid", 64'(w_s_valid), 64'd1);
      check_eq("wrap_pc", 64'(w_s_pc), 64'(wexp));
      wexp = wexp + 32'd1;
    end
    repeat (6) cycle();
    check_eq("steady_count", 64'(s_count), 64'd1);

    // backpressure from reset
    rst = 1'b1; cycle();
    rst = 1'b0; instr_ready = 1'b0;
    repeat (8) cycle();
    check_eq("bp_count", 64'(s_count), 64'(DEPTH));
    check_eq("bp_req", 64'(s_req), 64'd0);
    check_eq("bp_addr", 64'(s_addr), 64'd4);
    repeat (3) cycle();
    check_eq("bp_addr_hold", 64'(s_addr), 64'd4);
    instr_ready = 1'b1;
    repeat (12) cycle();

    // redirect with 3 buffered + 1 in flight, ready=0
    rst = 1'b1; cycle();
    rst = 1'b0; instr_ready = 1'b0;
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    check_eq("rd_pre_count", 64'(s_count), 64'd3);
    redirect = 1'b0;
    cycle();
    check_eq("rd_n1_req", 64'(s_req), 64'd1);
    check_eq("rd_n1_addr", 64'(s_addr), 64'h40);
    cycle();
    check_eq("rd_n2_valid", 64'(s_valid), 64'd0);
    cycle();
    check_eq("rd_n3_valid", 64'(s_valid), 64'd1);
    check_eq("rd_n3_pc", 64'(s_pc), 64'h40);
    instr_ready = 1'b1;
    repeat (8) cycle();

    // redirect coinciding with a completed handshake, then back-to-back
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    check_eq("rd_hs_valid", 64'(s_valid), 64'd1);
    redirect = 1'b0;
    repeat (8) cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    redirect = 1'b0;
    cycle();
    check_eq("b2b_addr", 64'(s_addr), 64'h300);
    cycle(); cycle();
    check_eq("b2b_pc", 64'(s_pc), 64'h300);
    repeat (8) cycle();

    // random ready with sporadic resets and redirects
    hs_start = n_hs;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      rst = (r < 2);
      redirect = (r >= 2 && r < 5);
      redirect_pc = $urandom;
      instr_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    repeat (10) cycle();
    check_eq("rand_progress", 64'(n_hs - hs_start > 50), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
